pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Sequences the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards and squashes wrong-path instructions on a taken branch.
- Launches and tracks the multi-cycle multiply/divide unit, stalling only instructions that need HI/LO or the unit itself.

Parameters:
MUL_LAT, 4, multiply latency in cycles (must be at least 1)
DIV_LAT, 32, divide latency in cycles (must be at least 1)
CNT_W, 6, latency counter width; must satisfy 2^CNT_W >= max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
IF_ID_Rs  in  5  Rs field of the instruction in ID
IF_ID_Rt  in  5  Rt field of the instruction in ID
IF_ID_UsesRt  in  1  the instruction in ID reads Rt as a source
ID_EX_Rt  in  5  destination Rt of the instruction in EX
ID_EX_MemRead  in  1  the instruction in EX is a load
EX_BranchTaken  in  1  the branch in EX resolved taken
ID_MdStart  in  1  the instruction in ID is mult or div
ID_MdDiv  in  1  qualifies ID_MdStart: 1 = div, 0 = mult
ID_MdRead  in  1  the instruction in ID is mfhi or mflo
PCWrite  out  1  PC load enable
IF_ID_Write  out  1  IF/ID register load enable
IF_ID_Flush  out  1  zero the IF/ID register at the next edge
ID_EX_Bubble  out  1  force ID/EX control fields to 0 at the next edge
MdGo  out  1  one-cycle start pulse to the mul/div unit
MdBusy  out  1  mul/div operation in flight

Behaviour:
- State: 1-bit FSM {RUN, MD_BUSY} plus a CNT_W-bit down-counter cnt.
- Reset:
  - While rst is low: state=RUN, cnt=0.
  - Output values during reset: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, MdGo=0, MdBusy=0.
  - Reset asserted mid-operation aborts the mul/div tracking immediately.
- Outputs are combinational from state and inputs. Defaults: PCWrite=1, IF_ID_Write=1, all other outputs 0.
- Hazard terms:
  - lu = ID_EX_MemRead AND ID_EX_Rt != 0 AND (ID_EX_Rt == IF_ID_Rs OR (IF_ID_UsesRt AND ID_EX_Rt == IF_ID_Rt)).
  - md_hz = state==MD_BUSY AND (ID_MdStart OR ID_MdRead).
- Priority, highest first:
  1. EX_BranchTaken: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, IF_ID_Write=1, MdGo=0. The ID instruction is squashed, so no stall and no launch occur.
  2. lu or md_hz: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, MdGo=0.
  3. state==RUN AND ID_MdStart: MdGo=1. On the edge, cnt := (ID_MdDiv ? DIV_LAT : MUL_LAT) - 1 and state := MD_BUSY.
- Load-use stall length is exactly 1 cycle: the bubble in EX clears lu.
- MD_BUSY:
  - MdBusy=1.
  - Every edge: if cnt==0, state := RUN; otherwise cnt := cnt-1.
  - Result: MdBusy stays high for exactly LAT cycles after the launch edge.
  - A taken branch does not cancel the in-flight operation.
  - Instructions other than mult/div/mfhi/mflo proceed unstalled.
- Simultaneous lu and md_hz: a single stall. State and counter still advance.
- An mfhi/mflo issued in RUN is not stalled.

Optional Feature:
STALL_CNT_EN
- Defined:
  - Adds input StallClr (1 bit) and output StallCount (16 bits).
  - StallCount increments on every edge where PCWrite==0 outside reset, and saturates at 0xFFFF.
  - StallClr=1 sets it to 0; StallClr has priority over the increment.
  - Reset value is 0.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
1. Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, then defaults. Repeat with ID_EX_Rt=0 -> no stall.
2. Mult then mflo: ID_MdStart=1, ID_MdDiv=0 -> MdGo for 1 cycle, then MdBusy=1 for 4 cycles. ID_MdRead=1 held from the next cycle -> PCWrite=0 for 4 cycles, released in the cycle MdBusy falls.
3. Div with independent instructions: DIV_LAT=32, ID_MdRead=0 -> MdBusy high 32 cycles, no stall cycles. A second ID_MdStart arriving at cycle 10 stalls until MdBusy falls, then gets MdGo.
4. Branch over hazard: EX_BranchTaken=1 together with lu=1 and md_hz=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, MdGo=0. An in-flight div keeps counting.
5. Reset mid-divide: drop rst at cycle 5 of 32 -> MdBusy=0 and reset output values immediately (asynchronous). After release, state=RUN and ID_MdStart is accepted.
6. STALL_CNT_EN defined: 3 load-use stalls plus a 4-cycle mflo stall -> StallCount=7. StallClr=1 -> 0. Force 0xFFFF with continued stalls -> holds 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage MIPS pipeline.
// Handles the PC and IF/ID/ID-EX sequencing, load-use hazards, taken-branch
// squashing and tracking of the multi-cycle multiply/divide unit.
// Optional build macro STALL_CNT_EN adds a saturating stall-cycle counter
// (StallClr input, StallCount output).
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic       IF_ID_UsesRt,
    input  logic [4:0] ID_EX_Rt,
    input  logic       ID_EX_MemRead,
    input  logic       EX_BranchTaken,
    input  logic       ID_MdStart,
    input  logic       ID_MdDiv,
    input  logic       ID_MdRead,
`ifdef STALL_CNT_EN
    input  logic        StallClr,
    output logic [15:0] StallCount,
`endif
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Bubble,
    output logic       MdGo,
    output logic       MdBusy
);

    // Counter preload values: the unit stays busy for exactly LAT cycles,
    // counting LAT-1 down to 0.
    localparam logic [CNT_W-1:0] MulInit = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DivInit = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic loadUse;
    logic mdHazard;
    logic launch;

    // An ID source matching a pending load destination (never $zero) must wait;
    // so must any instruction needing HI/LO or the unit while it is busy.
    assign loadUse  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    assign mdHazard = (state_q == MD_BUSY) && (ID_MdStart || ID_MdRead);
    assign launch   = !EX_BranchTaken && !loadUse && !mdHazard &&
                      (state_q == RUN) && ID_MdStart;

    // State register; reset drops any in-flight mul/div tracking at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: launch loads the latency counter, busy counts down to zero
    // regardless of branches or stalls in the front of the pipe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (launch) begin
                    state_d = MD_BUSY;
                    cnt_d   = ID_MdDiv ? DivInit : MulInit;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline control outputs: reset freezes and flushes, then a taken branch
    // beats any stall, a stall beats a launch.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        MdGo         = 1'b0;
        MdBusy       = (state_q == MD_BUSY);
        if (!rst) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            MdBusy       = 1'b0;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (loadUse || mdHazard) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (launch) begin
            MdGo = 1'b1;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stallCnt_q, stallCnt_d;

    // Stall-cycle counter: clear wins over counting, and it sticks at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (StallClr) begin
            stallCnt_d = '0;
        end else if (!PCWrite && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign StallCount = stallCnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Table of single-cycle vectors in RUN, then hand-written multi-cycle
// sequences (load-use, mult/mflo, div, branch during div, reset mid-divide,
// and the STALL_CNT_EN counter when that macro is defined).
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic [4:0] exRt;
        logic       memRead;
        logic       br;
        logic       mdStart;
        logic       mdDiv;
        logic       mdRead;
        logic [5:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ifIdRs, ifIdRt, idExRt;
    logic       ifIdUsesRt, idExMemRead, exBranchTaken, idMdStart, idMdDiv, idMdRead;
    logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdGo, mdBusy;
`ifdef STALL_CNT_EN
    logic        stallClr = 1'b0;
    logic [15:0] stallCount;
`endif

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl [12];
    vec_t idle;

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_ID_Rs       (ifIdRs),
        .IF_ID_Rt       (ifIdRt),
        .IF_ID_UsesRt   (ifIdUsesRt),
        .ID_EX_Rt       (idExRt),
        .ID_EX_MemRead  (idExMemRead),
        .EX_BranchTaken (exBranchTaken),
        .ID_MdStart     (idMdStart),
        .ID_MdDiv       (idMdDiv),
        .ID_MdRead      (idMdRead),
`ifdef STALL_CNT_EN
        .StallClr       (stallClr),
        .StallCount     (stallCount),
`endif
        .PCWrite        (pcWrite),
        .IF_ID_Write    (ifIdWrite),
        .IF_ID_Flush    (ifIdFlush),
        .ID_EX_Bubble   (idExBubble),
        .MdGo           (mdGo),
        .MdBusy         (mdBusy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                   input logic [4:0] exRt, input logic memRead, input logic br,
                                   input logic mdStart, input logic mdDiv, input logic mdRead,
                                   input logic [5:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.exRt = exRt; v.memRead = memRead;
        v.br = br; v.mdStart = mdStart; v.mdDiv = mdDiv; v.mdRead = mdRead; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        ifIdRs        = v.rs;
        ifIdRt        = v.rt;
        ifIdUsesRt    = v.usesRt;
        idExRt        = v.exRt;
        idExMemRead   = v.memRead;
        exBranchTaken = v.br;
        idMdStart     = v.mdStart;
        idMdDiv       = v.mdDiv;
        idMdRead      = v.mdRead;
    endtask

    // Expected order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MdGo, MdBusy}
    task automatic checkOutput(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdGo, mdBusy};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b (PCWrite,IF_ID_Write,IF_ID_Flush,ID_EX_Bubble,MdGo,MdBusy)",
                     name, act, exp);
        end
    endtask

`ifdef STALL_CNT_EN
    task automatic checkCount(input string name, input logic [15:0] exp);
        checks++;
        if (stallCount !== exp) begin
            failures++;
            $display("[TB] FAIL %s: StallCount got %0h, expected %0h", name, stallCount, exp);
        end
    endtask
`endif

    // One cycle: drive at the falling edge, sample 1 ns later, hold through the rising edge.
    task automatic cycle(input vec_t v, input string name, input logic [5:0] exp);
        @(negedge clk);
        applyStimulus(v);
        #1 checkOutput(name, exp);
    endtask

    initial begin
        idle = mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000);

        tbl[0]  = mkVec(5'd3, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000);
        tbl[1]  = mkVec(5'd8, 5'd4, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100);
        tbl[2]  = mkVec(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000);
        tbl[3]  = mkVec(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100);
        tbl[4]  = mkVec(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000);
        tbl[5]  = mkVec(5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000);
        tbl[6]  = mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111100);
        tbl[7]  = mkVec(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111100);
        tbl[8]  = mkVec(5'd2, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b110010);
        tbl[9]  = mkVec(5'd8, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000100);
        tbl[10] = mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b110000);
        tbl[11] = mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111100);

        // Reset state: outputs forced while rst is low, even with a start request.
        applyStimulus(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0));
        #3 checkOutput("reset outputs", 6'b001100);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(idle);
        rst = 1'b1;
        #1 checkOutput("after reset release", 6'b110000);

        // Table vectors, all in RUN; idle is restored before each rising edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1 checkOutput($sformatf("vec[%0d]", i), tbl[i].exp);
            #1 applyStimulus(idle);
        end

        // Load-use: one stall cycle, then the bubble in EX clears it.
        $display("[TB] load-use sequence");
        cycle(mkVec(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0), "lu stall", 6'b000100);
        cycle(mkVec(5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0), "lu released", 6'b110000);
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0), "lu rt0 no stall", 6'b110000);

        // Mult then mflo held: stalled for the 4 busy cycles, released as MdBusy falls.
        $display("[TB] mult/mflo sequence");
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0), "mult launch", 6'b110010);
        for (int k = 0; k < 4; k++)
            cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0),
                  $sformatf("mflo stall %0d", k), 6'b000101);
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0), "mflo release", 6'b110000);

        // Div with independent work, second start arriving in busy cycle 10.
        $display("[TB] div sequence");
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0), "div launch", 6'b110010);
        for (int k = 0; k < 32; k++) begin
            if (k >= 9)
                cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0),
                      $sformatf("div busy start-stall %0d", k), 6'b000101);
            else
                cycle(mkVec(5'd5, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0),
                      $sformatf("div busy %0d", k), 6'b110001);
        end
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0), "second launch", 6'b110010);
        for (int k = 0; k < 4; k++)
            cycle(idle, $sformatf("second mult busy %0d", k), 6'b110001);
        cycle(idle, "second mult done", 6'b110000);

        // Taken branch with lu and md_hz present; the div keeps counting.
        $display("[TB] branch during div sequence");
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0), "div2 launch", 6'b110010);
        for (int k = 0; k < 32; k++) begin
            if (k == 4)
                cycle(mkVec(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b0),
                      "branch over hazards", 6'b111101);
            else
                cycle(idle, $sformatf("div2 busy %0d", k), 6'b110001);
        end
        cycle(idle, "div2 done", 6'b110000);

        // Reset dropped in busy cycle 5 of a divide.
        $display("[TB] reset mid-divide sequence");
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0), "div3 launch", 6'b110010);
        for (int k = 0; k < 4; k++)
            cycle(idle, $sformatf("div3 busy %0d", k), 6'b110001);
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0), "div3 start stalled", 6'b000101);
        #1 rst = 1'b0;
        #1 checkOutput("async reset mid-div", 6'b001100);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(idle);
        rst = 1'b1;
        #1 checkOutput("run after reset", 6'b110000);
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0), "launch after reset", 6'b110010);
        for (int k = 0; k < 4; k++)
            cycle(idle, $sformatf("post-reset mult busy %0d", k), 6'b110001);
        cycle(idle, "post-reset mult done", 6'b110000);

`ifdef STALL_CNT_EN
        // Stall counter: 3 load-use stalls plus a 4-cycle mflo stall give 7.
        $display("[TB] stall counter sequence");
        @(negedge clk);
        stallClr = 1'b1;
        @(negedge clk);
        stallClr = 1'b0;
        #1 checkCount("count cleared", 16'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(mkVec(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0), "cnt lu", 6'b000100);
            cycle(idle, "cnt lu gap", 6'b110000);
        end
        cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0), "cnt mult launch", 6'b110010);
        for (int k = 0; k < 4; k++)
            cycle(mkVec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0), "cnt mflo stall", 6'b000101);
        cycle(idle, "cnt idle", 6'b110000);
        checkCount("seven stalls", 16'd7);
        // Clear wins even while a stall is present.
        cycle(mkVec(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0), "cnt clr stall", 6'b000100);
        stallClr = 1'b1;
        @(negedge clk);
        stallClr = 1'b0;
        #1 checkCount("clear beats stall", 16'd0);
        // Continuous stall up to saturation and beyond.
        repeat (65535) @(posedge clk);
        @(negedge clk);
        checkCount("saturated", 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCount("holds saturation", 16'hFFFF);
        applyStimulus(idle);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
